// File: rtl/coax_pkg.sv
// Shared definitions for the coax line controller: line state encoding,
// receiver error codes and timer sizing helpers.
package coax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TX_START   = 3'd1,
        ST_TX         = 3'd2,
        ST_TURNAROUND = 3'd3,
        ST_WAIT_RESP  = 3'd4,
        ST_RX         = 3'd5,
        ST_RECOVER    = 3'd6
    } line_state_e;

    // Error codes reported by coax_rx on rx_data while rx_error is high.
    localparam logic [9:0] RX_ERR_PARITY  = 10'h001;
    localparam logic [9:0] RX_ERR_FRAMING = 10'h002;
    localparam logic [9:0] RX_ERR_OVERRUN = 10'h004;
    localparam logic [9:0] RX_ERR_LOSS    = 10'h008;

    // Bits needed to hold values 0..max_count.
    function automatic int unsigned timer_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The first cycle in a timed state already shows the loaded value, so a
    // state that must last N cycles loads N-1 and leaves at count 0.
    function automatic int unsigned load_for(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/coax_ctrl_timer.sv
// Saturating down-counter; expired while the count sits at zero.
module coax_ctrl_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/coax_line_ctrl.sv
// Half-duplex coax line arbiter: sequences transmit, turnaround, response
// wait, receive and error recovery around coax_tx / coax_rx.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   IDLE          | listening; receive wins over a pending tx_req
//   TX_START      | tx_start issued, waiting for the transmitter to go busy
//   TX            | transmitter running
//   TURNAROUND    | line-quiet gap after transmit, receiver gated off
//   WAIT_RESP     | listening for the response start, bounded by a timeout
//   RX            | receiving words
//   RECOVER       | quiet period after a receive error
module coax_line_ctrl
    import coax_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT          = 8,
    parameter int unsigned TURNAROUND_CLOCKS       = 16,
    parameter int unsigned RESPONSE_TIMEOUT_CLOCKS = 1024,
    parameter int unsigned RECOVER_CLOCKS          = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_req,
    input  logic       tx_expect_response,
    output logic       tx_ack,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       rx_active,
    input  logic       rx_error,
    input  logic       rx_strobe,
    input  logic [9:0] rx_data,
    output logic       rx_enable,
    output logic       rx_reset,
    output logic [9:0] word,
    output logic       word_strobe,
    output logic       err,
    output logic [9:0] err_code,
    output logic       rx_done,
    output logic       resp_timeout,
    output logic       tx_fault,
    output logic       busy,
    output logic [2:0] line_state
);

    localparam int unsigned START_CLOCKS = 4 * CLOCKS_PER_BIT;
    localparam int unsigned TMR_MAX = max_u(max_u(START_CLOCKS, TURNAROUND_CLOCKS),
                                            max_u(RESPONSE_TIMEOUT_CLOCKS, RECOVER_CLOCKS));
    localparam int unsigned TW = timer_width(TMR_MAX);

    localparam logic [TW-1:0] LD_START = TW'(load_for(START_CLOCKS));
    localparam logic [TW-1:0] LD_TURN  = TW'(load_for(TURNAROUND_CLOCKS));
    localparam logic [TW-1:0] LD_RESP  = TW'(load_for(RESPONSE_TIMEOUT_CLOCKS));
    localparam logic [TW-1:0] LD_REC   = TW'(load_for(RECOVER_CLOCKS));

    line_state_e   state, state_next;
    logic          expect_q, expect_next;
    logic          tmr_load, tmr_enable, tmr_expired;
    logic [TW-1:0] tmr_value;
    logic          ack_next, fault_next, timeout_next, done_next, err_next, strobe_next;

    coax_ctrl_timer #(.WIDTH(TW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    assign tmr_enable = (state == ST_TX_START) || (state == ST_TURNAROUND) ||
                        (state == ST_WAIT_RESP) || (state == ST_RECOVER);

    // Next-state, timer loads and the pulse values registered below.
    always_comb begin
        state_next   = state;
        expect_next  = expect_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        ack_next     = 1'b0;
        fault_next   = 1'b0;
        timeout_next = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        strobe_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_active) begin
                    state_next = ST_RX;
                end else if (tx_req) begin
                    state_next  = ST_TX_START;
                    expect_next = tx_expect_response;
                    ack_next    = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_value   = LD_START;
                end
            end
            ST_TX_START: begin
                if (tx_busy) begin
                    state_next = ST_TX;
                end else if (tmr_expired) begin
                    fault_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_TX: begin
                if (!tx_busy) begin
                    state_next = ST_TURNAROUND;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_TURN;
                end
            end
            ST_TURNAROUND: begin
                if (tmr_expired) begin
                    if (expect_q) begin
                        state_next = ST_WAIT_RESP;
                        tmr_load   = 1'b1;
                        tmr_value  = LD_RESP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (rx_error) begin
                    err_next   = 1'b1;
                    state_next = ST_RECOVER;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_REC;
                end else if (rx_active) begin
                    state_next = ST_RX;
                end else if (tmr_expired) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_RX: begin
                if (rx_error) begin
                    err_next   = 1'b1;
                    state_next = ST_RECOVER;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_REC;
                end else begin
                    strobe_next = rx_strobe;
                    if (!rx_active) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RECOVER: begin
                if (tmr_expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and every output are registered from the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            expect_q     <= 1'b0;
            tx_ack       <= 1'b0;
            tx_start     <= 1'b0;
            rx_enable    <= 1'b0;
            rx_reset     <= 1'b0;
            word         <= '0;
            word_strobe  <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
            rx_done      <= 1'b0;
            resp_timeout <= 1'b0;
            tx_fault     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            expect_q     <= expect_next;
            tx_ack       <= ack_next;
            tx_start     <= ack_next;
            rx_enable    <= (state_next == ST_IDLE) || (state_next == ST_WAIT_RESP) ||
                            (state_next == ST_RX);
            rx_reset     <= err_next;
            word_strobe  <= strobe_next;
            err          <= err_next;
            rx_done      <= done_next;
            resp_timeout <= timeout_next;
            tx_fault     <= fault_next;
            busy         <= (state_next != ST_IDLE);
            if (strobe_next) begin
                word <= rx_data;
            end
            if (err_next) begin
                err_code <= rx_data;
            end
        end
    end

    assign line_state = state;

endmodule

// File: tb/tb_coax_line_ctrl.sv
// Scenario bench for coax_line_ctrl with a scoreboard for received words and errors.
module tb_coax_line_ctrl;
    import coax_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tx_req = 1'b0, tx_expect_response = 1'b0, tx_busy = 1'b0;
    logic       rx_active = 1'b0, rx_error = 1'b0, rx_strobe = 1'b0;
    logic [9:0] rx_data = '0;
    logic       tx_ack, tx_start, rx_enable, rx_reset, word_strobe, err;
    logic       rx_done, resp_timeout, tx_fault, busy;
    logic [9:0] word, err_code;
    logic [2:0] line_state;

    int n_tests = 0, n_fail = 0;
    int n_word = 0, n_done = 0, n_to = 0, n_ack = 0, n_fault = 0, n_err = 0;
    logic [9:0] exp_word[$];
    logic [9:0] exp_err[$];

    coax_line_ctrl #(
        .CLOCKS_PER_BIT(8), .TURNAROUND_CLOCKS(16),
        .RESPONSE_TIMEOUT_CLOCKS(1024), .RECOVER_CLOCKS(24)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_req(tx_req), .tx_expect_response(tx_expect_response),
        .tx_ack(tx_ack), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_active(rx_active), .rx_error(rx_error), .rx_strobe(rx_strobe), .rx_data(rx_data),
        .rx_enable(rx_enable), .rx_reset(rx_reset),
        .word(word), .word_strobe(word_strobe), .err(err), .err_code(err_code),
        .rx_done(rx_done), .resp_timeout(resp_timeout), .tx_fault(tx_fault),
        .busy(busy), .line_state(line_state)
    );

    always #5 clk = ~clk;

    // Scoreboard side: pop expectations when the DUT emits words or errors.
    always @(negedge clk) begin
        if (word_strobe === 1'b1) begin
            n_word++;
            n_tests++;
            if (exp_word.size() == 0) begin
                n_fail++;
                $display("FAIL sb_word: unexpected word_strobe, word=%h", word);
            end else begin
                logic [9:0] w;
                w = exp_word.pop_front();
                if (word !== w) begin
                    n_fail++;
                    $display("FAIL sb_word: word=%h want %h", word, w);
                end
            end
        end
        if (err === 1'b1) begin
            n_err++;
            n_tests++;
            if (exp_err.size() == 0) begin
                n_fail++;
                $display("FAIL sb_err: unexpected err, err_code=%h", err_code);
            end else begin
                logic [9:0] e;
                e = exp_err.pop_front();
                if (err_code !== e || rx_reset !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sb_err: err_code=%h rx_reset=%b want %h/1", err_code, rx_reset, e);
                end
            end
        end
        if (rx_done === 1'b1) n_done++;
        if (resp_timeout === 1'b1) n_to++;
        if (tx_ack === 1'b1) n_ack++;
        if (tx_fault === 1'b1) n_fault++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (line_state !== target && n < budget) begin
            step();
            n++;
        end
        n_tests++;
        if (line_state !== target) begin
            n_fail++;
            $display("FAIL %s: line_state=%0d want %0d within %0d cycles", name, line_state, target, budget);
        end
    endtask

    task automatic start_tx(input logic expect_resp, input int busy_cycles);
        tx_expect_response = expect_resp;
        tx_req = 1'b1;
        step();
        tx_req = 1'b0;
        tx_busy = 1'b1;
        repeat (busy_cycles) step();
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_tests++;
        if (line_state !== 3'd0 || busy !== 1'b0 || rx_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: line_state=%0d busy=%b rx_enable=%b want 0/0/0", line_state, busy, rx_enable);
        end
        n_tests++;
        if (word !== 10'h0 || err_code !== 10'h0 || tx_ack !== 1'b0 || tx_start !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: word=%h err_code=%h ack=%b start=%b err=%b want zeros", word, err_code, tx_ack, tx_start, err);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        n_tests++;
        if (rx_enable !== 1'b1 || line_state !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rx_enable=%b line_state=%0d busy=%b want 1/0/0", rx_enable, line_state, busy);
        end
    endtask

    task automatic test_tx_no_response();
        int n, to0, ack0;
        to0 = n_to;
        ack0 = n_ack;
        tx_expect_response = 1'b0;
        tx_req = 1'b1;
        step();
        n_tests++;
        if (tx_ack !== 1'b1 || tx_start !== 1'b1 || line_state !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_grant: ack=%b start=%b line_state=%0d busy=%b want 1/1/1/1", tx_ack, tx_start, line_state, busy);
        end
        tx_req = 1'b0;
        tx_busy = 1'b1;
        step();
        n_tests++;
        if (line_state !== 3'd2 || tx_ack !== 1'b0 || tx_start !== 1'b0 || rx_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_enter: line_state=%0d ack=%b start=%b rx_enable=%b want 2/0/0/0", line_state, tx_ack, tx_start, rx_enable);
        end
        repeat (99) step();
        tx_busy = 1'b0;
        step();
        n = 0;
        while (line_state === 3'd3 && n < 100) begin
            n++;
            step();
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL turnaround_len: %0d cycles want 16", n);
        end
        n_tests++;
        if (line_state !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_back_idle: line_state=%0d busy=%b want 0/0", line_state, busy);
        end
        step();
        n_tests++;
        if (n_to != to0 || n_ack != ack0 + 1) begin
            n_fail++;
            $display("FAIL tx_pulse_counts: timeouts=%0d acks=%0d want 0/1", n_to - to0, n_ack - ack0);
        end
    endtask

    task automatic test_response_words();
        logic [9:0] words [3] = '{10'h155, 10'h0AA, 10'h3FF};
        int done0, w0;
        start_tx(1'b1, 10);
        wait_state(3'd4, 40, "turn_to_wait");
        repeat (200) step();
        n_tests++;
        if (line_state !== 3'd4 || rx_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_hold: line_state=%0d rx_enable=%b want 4/1", line_state, rx_enable);
        end
        done0 = n_done;
        w0 = n_word;
        rx_active = 1'b1;
        step();
        n_tests++;
        if (line_state !== 3'd5) begin
            n_fail++;
            $display("FAIL rx_enter: line_state=%0d want 5", line_state);
        end
        for (int i = 0; i < 3; i++) begin
            exp_word.push_back(words[i]);
            rx_data = words[i];
            rx_strobe = 1'b1;
            step();
            rx_strobe = 1'b0;
            rx_data = 10'h0;
            n_tests++;
            if (word_strobe !== 1'b1) begin
                n_fail++;
                $display("FAIL word_latency: word %0d strobe=%b want 1", i, word_strobe);
            end
            step();
            step();
        end
        rx_active = 1'b0;
        step();
        n_tests++;
        if (rx_done !== 1'b1 || line_state !== 3'd0) begin
            n_fail++;
            $display("FAIL rx_done: rx_done=%b line_state=%0d want 1/0", rx_done, line_state);
        end
        // A strobe outside RX must not produce a word.
        rx_data = 10'h111;
        rx_strobe = 1'b1;
        step();
        step();
        rx_strobe = 1'b0;
        rx_data = 10'h0;
        step();
        n_tests++;
        if (n_done != done0 + 1 || n_word != w0 + 3 || exp_word.size() != 0) begin
            n_fail++;
            $display("FAIL rx_counts: done=%0d words=%0d pending=%0d want 1/3/0", n_done - done0, n_word - w0, exp_word.size());
        end
    endtask

    task automatic test_resp_timeout();
        int n;
        start_tx(1'b1, 5);
        wait_state(3'd4, 40, "timeout_wait_entry");
        n = 0;
        while (resp_timeout !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        n_tests++;
        if (n != 1024) begin
            n_fail++;
            $display("FAIL resp_timeout_len: %0d cycles want 1024", n);
        end
        n_tests++;
        if (line_state !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_idle: line_state=%0d want 0", line_state);
        end
    endtask

    task automatic test_rx_error();
        int n, done0;
        done0 = n_done;
        rx_active = 1'b1;
        step();
        exp_err.push_back(RX_ERR_FRAMING);
        rx_data = RX_ERR_FRAMING;
        rx_error = 1'b1;
        step();
        n_tests++;
        if (err !== 1'b1 || err_code !== 10'h002 || rx_reset !== 1'b1 || line_state !== 3'd6) begin
            n_fail++;
            $display("FAIL err_pulse: err=%b code=%h rx_reset=%b line_state=%0d want 1/002/1/6", err, err_code, rx_reset, line_state);
        end
        rx_error = 1'b0;
        rx_active = 1'b0;
        rx_data = 10'h0;
        step();
        n_tests++;
        if (err !== 1'b0 || rx_reset !== 1'b0 || rx_enable !== 1'b0 || err_code !== 10'h002) begin
            n_fail++;
            $display("FAIL err_one_cycle: err=%b rx_reset=%b rx_enable=%b code=%h want 0/0/0/002", err, rx_reset, rx_enable, err_code);
        end
        n = 1;
        while (line_state === 3'd6 && n < 100) begin
            step();
            n++;
        end
        n_tests++;
        if (n != 24 || line_state !== 3'd0) begin
            n_fail++;
            $display("FAIL recover_len: %0d cycles to line_state=%0d want 24 to 0", n, line_state);
        end
        n_tests++;
        if (n_done != done0 || exp_err.size() != 0) begin
            n_fail++;
            $display("FAIL err_counts: rx_done=%0d pending=%0d want 0/0", n_done - done0, exp_err.size());
        end
    endtask

    task automatic test_collision_and_fault();
        int n, fault0;
        fault0 = n_fault;
        tx_expect_response = 1'b0;
        tx_req = 1'b1;
        rx_active = 1'b1;
        step();
        n_tests++;
        if (line_state !== 3'd5 || tx_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_rx_wins: line_state=%0d ack=%b want 5/0", line_state, tx_ack);
        end
        rx_active = 1'b0;
        step();
        n_tests++;
        if (rx_done !== 1'b1 || tx_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_done: rx_done=%b ack=%b want 1/0", rx_done, tx_ack);
        end
        step();
        n_tests++;
        if (tx_ack !== 1'b1 || tx_start !== 1'b1 || line_state !== 3'd1) begin
            n_fail++;
            $display("FAIL collision_ack_after: ack=%b start=%b line_state=%0d want 1/1/1", tx_ack, tx_start, line_state);
        end
        tx_req = 1'b0;
        n = 0;
        while (tx_fault !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_tests++;
        if (n != 32 || line_state !== 3'd0) begin
            n_fail++;
            $display("FAIL tx_fault_len: %0d cycles line_state=%0d want 32/0", n, line_state);
        end
        step();
        n_tests++;
        if (n_fault != fault0 + 1 || tx_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_fault_pulse: count=%0d level=%b want 1/0", n_fault - fault0, tx_fault);
        end
    endtask

    task automatic test_reset_mid_rx();
        int done0, err0, to0;
        rx_active = 1'b1;
        step();
        rx_data = 10'h2A5;
        rx_strobe = 1'b1;
        step();
        rx_strobe = 1'b0;
        n_tests++;
        if (line_state !== 3'd5 || word !== 10'h2A5) begin
            n_fail++;
            $display("FAIL pre_reset_rx: line_state=%0d word=%h want 5/2a5", line_state, word);
        end
        done0 = n_done;
        err0 = n_err;
        to0 = n_to;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (line_state !== 3'd0 || busy !== 1'b0 || rx_enable !== 1'b0 || word !== 10'h0 ||
            err_code !== 10'h0 || word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: line_state=%0d busy=%b rx_enable=%b word=%h code=%h ws=%b want 0/0/0/0/0/0",
                     line_state, busy, rx_enable, word, err_code, word_strobe);
        end
        rx_active = 1'b0;
        rx_data = 10'h0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        step();
        n_tests++;
        if (n_done != done0 || n_err != err0 || n_to != to0 || rx_enable !== 1'b1 || line_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_abandon: done=%0d err=%0d to=%0d rx_enable=%b line_state=%0d want 0/0/0/1/0",
                     n_done - done0, n_err - err0, n_to - to0, rx_enable, line_state);
        end
    endtask

    initial begin
        test_reset();
        test_tx_no_response();
        test_response_words();
        test_resp_timeout();
        test_rx_error();
        test_collision_and_fault();
        test_reset_mid_rx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
